// File: rtl/mem_dp_clr.sv
`default_nettype none
// ============================================================================
// Module   : mem_dp_clr
// Purpose  : Simple-dual-port synchronous RAM with 1-cycle read request/valid
//            and a hardware clear sequencer that zeroes every entry after reset
//            or on a clr pulse. Optional macro MEM_BYPASS_EN selects write-first
//            forwarding on a same-address read/write collision (read-first if
//            undefined).
// Revision : 1.0 - initial release
// ============================================================================
module mem_dp_clr #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          drop
);

  localparam int            c_depth     = 2**AW;
  localparam logic [AW-1:0] c_last_addr = AW'(c_depth - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] w_clr_cnt_nxt;

  logic [W-1:0]  r_mem [c_depth];

  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [W-1:0]  w_mem_wdata;
  logic          w_rd_accept;
  logic          w_req_dropped;
  logic [W-1:0]  w_rd_word;

  logic [W-1:0]  r_rd_data;
  logic          r_rd_valid;
  logic          r_drop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // The clear sequencer and the user write share the single array write port.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_mem_we      = 1'b0;
    w_mem_addr    = wr_addr;
    w_mem_wdata   = wr_data;
    w_rd_accept   = 1'b0;
    w_req_dropped = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_mem_we      = 1'b1;
        w_mem_addr    = r_clr_cnt;
        w_mem_wdata   = '0;
        w_req_dropped = wr_en | rd_en;
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == c_last_addr) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        w_mem_we    = wr_en;
        w_rd_accept = rd_en;
        if (clr) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  // Array has no reset; a reset cycle must not disturb its contents.
  always_ff @(posedge clk) begin
    if (reset && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

`ifdef MEM_BYPASS_EN
  assign w_rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_data : r_mem[rd_addr];
`else
  assign w_rd_word = r_mem[rd_addr];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_accept;
      r_drop     <= w_req_dropped;
      if (w_rd_accept) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign drop     = r_drop;
  assign busy     = (r_state == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_mem_dp_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dp_clr
// Purpose  : Self-checking bench for mem_dp_clr: directed scenarios plus
//            randomized traffic against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_dp_clr;

  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          busy;
  logic          drop;

  always #5 clk = ~clk;

  mem_dp_clr #(.W(W), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .drop     (drop)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: contents, remaining clear cycles, expected registered outputs.
  logic [W-1:0] ref_mem [DEPTH];
  int           clear_left = DEPTH;
  logic [W-1:0] exp_data   = '0;
  logic         exp_valid  = 1'b0;
  logic         exp_drop   = 1'b0;

  task automatic idle_inputs();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  // Advance the model with the inputs present before the edge, then the clock.
  task automatic tick();
    if (!reset) begin
      clear_left = DEPTH;
      exp_data   = '0;
      exp_valid  = 1'b0;
      exp_drop   = 1'b0;
    end else if (clear_left > 0) begin
      ref_mem[DEPTH - clear_left] = '0;
      clear_left = clear_left - 1;
      exp_valid  = 1'b0;
      exp_drop   = wr_en | rd_en;
    end else begin
      exp_drop  = 1'b0;
      exp_valid = rd_en;
      if (rd_en) begin
        exp_data = ref_mem[rd_addr];
`ifdef MEM_BYPASS_EN
        if (wr_en && wr_addr == rd_addr) exp_data = wr_data;
`endif
      end
      if (wr_en) ref_mem[wr_addr] = wr_data;
      if (clr) clear_left = DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({busy, drop, rd_valid, rd_data} !== {3'b100, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state: busy/drop/valid/data=%b%b%b/%h expected 100/00", busy, drop, rd_valid, rd_data);
    end
    reset = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      n_vec++;
      if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
        n_err++;
        $display("FAIL reset_clear_outputs: valid=%b data=%h expected 0/00", rd_valid, rd_data);
      end
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt !== 16) begin
      n_err++;
      $display("FAIL reset_busy_len: busy cycles=%0d expected 16", cnt);
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    tick();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      n_err++;
      $display("FAIL read_written: valid=%b data=%h expected 1/a5", rd_valid, rd_data);
    end
    rd_addr = 4'd7;
    tick();
    idle_inputs();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL read_unwritten: valid=%b data=%h expected 1/00", rd_valid, rd_data);
    end
    tick();
    n_vec++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || drop !== 1'b0) begin
      n_err++;
      $display("FAIL read_hold: valid=%b data=%h drop=%b expected 0/00/0", rd_valid, rd_data, drop);
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] want;
`ifdef MEM_BYPASS_EN
    want = 8'h3C;
`else
    want = 8'h11;
`endif
    idle_inputs();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h11;
    tick();
    wr_data = 8'h3C;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    idle_inputs();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== want) begin
      n_err++;
      $display("FAIL collision: valid=%b data=%h expected 1/%h", rd_valid, rd_data, want);
    end
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    idle_inputs();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
      n_err++;
      $display("FAIL collision_after: valid=%b data=%h expected 1/3c", rd_valid, rd_data);
    end
  endtask

  task automatic test_clear_request();
    int cnt;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = W'(i) ^ 8'hFF;
      tick();
    end
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (cnt == 0) begin
        rd_en = 1'b1; rd_addr = 4'd0;
      end else begin
        rd_en = 1'b0;
      end
      tick();
      cnt++;
      if (cnt == 1) begin
        n_vec++;
        if (drop !== 1'b1 || rd_valid !== 1'b0) begin
          n_err++;
          $display("FAIL busy_drop: drop=%b valid=%b expected 1/0", drop, rd_valid);
        end
      end
    end
    n_vec++;
    if (cnt !== 16) begin
      n_err++;
      $display("FAIL clr_busy_len: busy cycles=%0d expected 16", cnt);
    end
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      tick();
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h00 || drop !== 1'b0) begin
        n_err++;
        $display("FAIL cleared_entry: addr=%0d valid=%b data=%h drop=%b expected 1/00/0", i, rd_valid, rd_data, drop);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = W'(i + 1);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      tick();
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== W'(i + 1)) begin
        n_err++;
        $display("FAIL b2b_read: idx=%0d valid=%b data=%h expected 1/%h", i, rd_valid, rd_data, W'(i + 1));
      end
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (rd_valid !== 1'b0 || rd_data !== 8'h03) begin
        n_err++;
        $display("FAIL b2b_hold: valid=%b data=%h expected 0/03", rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_vec++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL midclr_reset: busy=%b valid=%b data=%h expected 1/0/00", busy, rd_valid, rd_data);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt !== 16) begin
      n_err++;
      $display("FAIL midclr_busy_len: busy cycles=%0d expected 16", cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 99) != 0);
      clr     = ($urandom_range(0, 39) == 0);
      wr_en   = $urandom_range(0, 1) == 1;
      rd_en   = $urandom_range(0, 1) == 1;
      wr_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      rd_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wr_data = W'($urandom);
      tick();
      n_vec++;
      if ({busy, drop, rd_valid, rd_data} !== {(clear_left > 0), exp_drop, exp_valid, exp_data}) begin
        n_err++;
        $display("FAIL random[%0d]: busy/drop/valid/data=%b%b%b/%h expected %b%b%b/%h",
                 i, busy, drop, rd_valid, rd_data, (clear_left > 0), exp_drop, exp_valid, exp_data);
      end
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_collision();
    test_clear_request();
    test_back_to_back();
    test_reset_mid_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
